// File: rtl/pwm_relay_decoder.sv
// pwm_relay_decoder
// Multi-channel RC/PWM pulse-width decoder driving relay enables.
// Each channel synchronises its AUX input, measures the high width,
// classifies it as ON / OFF / HOLD, and changes its relay only after
// CONFIRM consecutive agreeing pulses. If no rising edge arrives within
// TIMEOUT clocks, the channel is declared lost and its relay is forced off.
module pwm_relay_decoder #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 26,
    parameter int ON_THRESH  = 95000,
    parameter int OFF_THRESH = 50500,
    parameter int CONFIRM    = 3,
    parameter int TIMEOUT    = 3150000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [NUM_CH-1:0]       AUX_INPUT,
    output logic [NUM_CH-1:0]       RELAY_ON,
    output logic [NUM_CH-1:0]       SIGNAL_LOST,
    output logic [NUM_CH-1:0]       WIDTH_VALID,
    output logic [NUM_CH*CNT_W-1:0] PULSE_WIDTH
);

    localparam int AGR_W = $clog2(CONFIRM + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ON_T     = CNT_W'(ON_THRESH);
    localparam logic [CNT_W-1:0] OFF_T    = CNT_W'(OFF_THRESH);
    // Idle count one short of TIMEOUT: the next increment reaches it.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [AGR_W-1:0] AGR_FULL = AGR_W'(CONFIRM);
    localparam logic [AGR_W-1:0] AGR_ONE  = AGR_W'(1);

    typedef enum logic { WAIT_RISE, MEAS_HIGH } state_t;
    typedef enum logic [1:0] { CLS_HOLD, CLS_OFF, CLS_ON } class_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sync_1, sync_2, sync_3;
        logic             rise, fall, timeout;
        state_t           state;
        class_t           cls, prev_cls;
        logic [CNT_W-1:0] high_cnt, idle_cnt, high_inc, idle_inc, width_q;
        logic [AGR_W-1:0] agree_cnt, agree_nxt;
        logic             relay_q, lost_q, valid_q;

        // Two-flop synchroniser plus one delay flop for edge detection.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_1 <= 1'b0;
                sync_2 <= 1'b0;
                sync_3 <= 1'b0;
            end else begin
                // NOTE: non-blocking so each flop takes its neighbour's old value and the chain shifts by one stage per clock.
                sync_1 <= AUX_INPUT[i];
                sync_2 <= sync_1;
                sync_3 <= sync_2;
            end
        end

        assign rise     = sync_2 & ~sync_3;
        assign fall     = ~sync_2 & sync_3;
        assign high_inc = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + 1'b1;
        assign idle_inc = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
        // Fires once, on the clock where the idle count reaches TIMEOUT.
        assign timeout  = (idle_cnt == TO_LAST);

        // Classify the width being latched and work out the next agreement count.
        always_comb begin
            // NOTE: every output gets a default first so no path leaves a latch behind.
            cls       = CLS_HOLD;
            agree_nxt = '0;
            if (high_cnt >= ON_T) begin
                cls = CLS_ON;
            end else if (high_cnt <= OFF_T) begin
                cls = CLS_OFF;
            end
            if (cls != CLS_HOLD) begin
                if (cls != prev_cls) begin
                    agree_nxt = AGR_ONE;
                end else if (agree_cnt == AGR_FULL) begin
                    agree_nxt = AGR_FULL;
                end else begin
                    agree_nxt = agree_cnt + 1'b1;
                end
            end
        end

        // Per-channel measurement FSM; timeout overrides every other event.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state     <= WAIT_RISE;
                high_cnt  <= '0;
                idle_cnt  <= '0;
                agree_cnt <= '0;
                prev_cls  <= CLS_HOLD;
                width_q   <= '0;
                relay_q   <= 1'b0;
                lost_q    <= 1'b1;
                valid_q   <= 1'b0;
            end else begin
                valid_q  <= 1'b0;
                idle_cnt <= idle_inc;
                if (timeout) begin
                    lost_q    <= 1'b1;
                    relay_q   <= 1'b0;
                    agree_cnt <= '0;
                    state     <= WAIT_RISE;
                end else begin
                    case (state)
                        WAIT_RISE: begin
                            if (rise) begin
                                high_cnt <= CNT_W'(1);
                                idle_cnt <= '0;
                                state    <= MEAS_HIGH;
                            end
                        end
                        MEAS_HIGH: begin
                            if (fall) begin
                                width_q   <= high_cnt;
                                valid_q   <= 1'b1;
                                lost_q    <= 1'b0;
                                agree_cnt <= agree_nxt;
                                prev_cls  <= cls;
                                if (cls != CLS_HOLD && agree_nxt == AGR_FULL) begin
                                    relay_q <= (cls == CLS_ON);
                                end
                                state <= WAIT_RISE;
                            end else if (sync_2) begin
                                high_cnt <= high_inc;
                            end
                        end
                        default: state <= WAIT_RISE;
                    endcase
                end
            end
        end

        assign RELAY_ON[i]                  = relay_q;
        assign SIGNAL_LOST[i]               = lost_q;
        assign WIDTH_VALID[i]               = valid_q;
        assign PULSE_WIDTH[i*CNT_W +: CNT_W] = width_q;
    end

endmodule
